// File: rtl/serial_link_cfg_responder.sv
// serial_link_cfg_responder: link config register target with one-cycle registered response.
// Build with SERIAL_LINK_CFG_TIMEOUT_EN to add the isolation-handshake watchdog.
module serial_link_cfg_responder #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  output logic                 reg_ready_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_error_o,
  output logic                 clk_ena_o,
  output logic                 link_rst_no,
  output logic [1:0]           isolate_req_o,
  input  logic [1:0]           isolated_i,
  output logic [1:0]           alloc_tx_cfg_o,
  output logic [1:0]           alloc_rx_cfg_o,
  output logic                 timeout_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [1:0]  ctrl_lo_q, ctrl_lo_d, iso_q, iso_d, tx_q, tx_d, rx_q, rx_d;
  logic [1:0]  isolated_q, to_q, to_d, to_set;
  logic [31:0] rdata_q, rdata_d, rd_word;
  logic        error_q, error_d, accept, addr_ok, wr;
  logic [1:0]  a;
  logic        unused_ok;
  assign a       = reg_addr_i[3:2];
  assign accept  = state_q == IDLE && reg_valid_i;
  assign addr_ok = (reg_addr_i & ~AddrWidth'(12)) == '0;
  assign wr      = accept && addr_ok && reg_write_i;
  assign rd_word = a == 2'd0 ? {22'd0, iso_q, 6'd0, ctrl_lo_q} :
                   a == 2'd1 ? {22'd0, to_q, 6'd0, isolated_q} :
                   a == 2'd2 ? {30'd0, tx_q} : {30'd0, rx_q};
  always_comb begin
    state_d   = accept ? RESP : IDLE;
    ctrl_lo_d = (wr && a == 2'd0 && reg_wstrb_i[0]) ? reg_wdata_i[1:0] : ctrl_lo_q;
    iso_d     = (wr && a == 2'd0 && reg_wstrb_i[1]) ? reg_wdata_i[9:8] : iso_q;
    tx_d      = (wr && a == 2'd2 && reg_wstrb_i[0]) ? reg_wdata_i[1:0] : tx_q;
    rx_d      = (wr && a == 2'd3 && reg_wstrb_i[0]) ? reg_wdata_i[1:0] : rx_q;
    // set is OR-ed after the clear so a same-cycle timeout wins
    to_d      = (to_q & ~((wr && a == 2'd1 && reg_wstrb_i[1]) ? reg_wdata_i[9:8] : 2'b00)) | to_set;
    rdata_d   = (accept && addr_ok && !reg_write_i) ? rd_word : 32'd0;
    error_d   = accept && !addr_ok;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ctrl_lo_q  <= 2'b00;
      iso_q      <= 2'b11;
      tx_q       <= 2'b00;
      rx_q       <= 2'b00;
      to_q       <= 2'b00;
      isolated_q <= 2'b00;
      rdata_q    <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_lo_q  <= ctrl_lo_d;
      iso_q      <= iso_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      to_q       <= to_d;
      isolated_q <= isolated_i;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end
`ifdef SERIAL_LINK_CFG_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TimeoutCycles + 1);
  for (genvar k = 0; k < 2; k++) begin : g_wd
    logic [CW-1:0] cnt_q;
    logic          busy;
    assign busy = iso_q[k] != isolated_q[k];
    // fires only on the step that reaches the limit, so W1C sticks while saturated
    assign to_set[k] = busy && cnt_q == CW'(TimeoutCycles - 1);
    always_ff @(posedge clk_i) begin
      if (rst_i || !busy) cnt_q <= '0;
      else if (cnt_q != CW'(TimeoutCycles)) cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign to_set = 2'b00;
`endif
  assign unused_ok      = ^{reg_wdata_i[31:10], reg_wdata_i[7:2], reg_wstrb_i[3:2]};
  assign reg_ready_o    = state_q == RESP;
  assign reg_rdata_o    = rdata_q;
  assign reg_error_o    = error_q;
  assign clk_ena_o      = ctrl_lo_q[0];
  assign link_rst_no    = ctrl_lo_q[1];
  assign isolate_req_o  = iso_q;
  assign alloc_tx_cfg_o = tx_q;
  assign alloc_rx_cfg_o = rx_q;
  assign timeout_o      = |to_q;
endmodule

// File: tb/tb_serial_link_cfg_responder.sv
// tb_serial_link_cfg_responder: directed self-checking bench for serial_link_cfg_responder.
module tb_serial_link_cfg_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready, error, clk_ena, link_rst_n, timeout;
  logic [31:0] rdata;
  logic [1:0]  iso_req, alloc_tx, alloc_rx;
  logic [1:0]  isolated = 2'b11;
  int          checks = 0, failures = 0;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  serial_link_cfg_responder #(.AddrWidth(32), .TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_i(rst), .reg_valid_i(valid), .reg_write_i(write),
    .reg_addr_i(addr), .reg_wdata_i(wdata), .reg_wstrb_i(wstrb),
    .reg_ready_o(ready), .reg_rdata_o(rdata), .reg_error_o(error),
    .clk_ena_o(clk_ena), .link_rst_no(link_rst_n), .isolate_req_o(iso_req),
    .isolated_i(isolated), .alloc_tx_cfg_o(alloc_tx), .alloc_rx_cfg_o(alloc_rx),
    .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output logic e);
    @(negedge clk);
    chk("ready_idle", {31'd0, ready}, 32'd0);
    valid = 1'b1; write = w; addr = a; wdata = d; wstrb = s;
    @(negedge clk);
    chk("ready_pulse", {31'd0, ready}, 32'd1);
    r = rdata; e = error;
    valid = 1'b0;
    @(negedge clk);
    chk("ready_drop", {31'd0, ready}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    acc(1'b0, a, 32'd0, 4'h0, rd, er);
    chk(tag, rd, exp);
    chk({tag, "_err"}, {31'd0, er}, 32'd0);
  endtask

  task automatic wr_ok(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    acc(1'b1, a, d, s, rd, er);
    chk("wr_err", {31'd0, er}, 32'd0);
    chk("wr_rdata", rd, 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_outs"}, {22'd0, clk_ena, link_rst_n, iso_req, alloc_tx, alloc_rx, timeout},
        {22'd0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;
    rd_chk("rd_ctrl", 32'h0, 32'h300);
    rd_chk("rd_iso", 32'h4, 32'h3);
    rd_chk("rd_tx", 32'h8, 32'h0);
    rd_chk("rd_rx", 32'hC, 32'h0);
    wr_ok(32'h0, 32'h300, 4'hF);
    chk("link_rst_lo", {31'd0, link_rst_n}, 32'd0);
    wr_ok(32'h0, 32'h302, 4'hF);
    chk("link_rst_hi", {31'd0, link_rst_n}, 32'd1);
    wr_ok(32'h0, 32'h303, 4'hF);
    chk("clk_ena", {31'd0, clk_ena}, 32'd1);
    wr_ok(32'h8, 32'h3, 4'hF);
    wr_ok(32'hC, 32'h3, 4'hF);
    chk("alloc_cfg", {28'd0, alloc_tx, alloc_rx}, 32'hF);
    rd_chk("rd_ctrl_303", 32'h0, 32'h303);
    // release isolation: status holds for a while, then follows
    wr_ok(32'h0, 32'h3, 4'hF);
    chk("iso_req_0", {30'd0, iso_req}, 32'd0);
    repeat (5) @(negedge clk);
    rd_chk("iso_before_drop", 32'h4, 32'h3);
    isolated = 2'b00;
    rd_chk("iso_after_drop", 32'h4, 32'h0);
    chk("no_timeout", {31'd0, timeout}, 32'd0);
    isolated = 2'b11;
    wr_ok(32'h0, 32'h303, 4'hF);
    repeat (2) @(negedge clk);
    wr_ok(32'h0, 32'h3, 4'hF);
    repeat (8) @(negedge clk);
    chk("timeout_early", {31'd0, timeout}, 32'd0);
    repeat (10) @(negedge clk);
`ifdef SERIAL_LINK_CFG_TIMEOUT_EN
    chk("timeout_set", {31'd0, timeout}, 32'd1);
    rd_chk("iso_timeout", 32'h4, 32'h303);
    wr_ok(32'h4, 32'h100, 4'hF);
    rd_chk("iso_w1c", 32'h4, 32'h203);
    chk("timeout_still", {31'd0, timeout}, 32'd1);
`else
    chk("timeout_off", {31'd0, timeout}, 32'd0);
    rd_chk("iso_no_wd", 32'h4, 32'h3);
    wr_ok(32'h4, 32'h303, 4'hF);
    rd_chk("iso_no_wd_w", 32'h4, 32'h3);
`endif
    wr_ok(32'h0, 32'h303, 4'hF);
    acc(1'b0, 32'h10, 32'd0, 4'h0, rd, er);
    chk("err_rd10", {31'd0, er}, 32'd1);
    chk("err_rd10_data", rd, 32'd0);
    acc(1'b0, 32'h8000_0004, 32'd0, 4'h0, rd, er);
    chk("err_hi_bit", {31'd0, er}, 32'd1);
    acc(1'b1, 32'h2, 32'h0, 4'hF, rd, er);
    chk("err_misalign", {31'd0, er}, 32'd1);
    rd_chk("ctrl_unchanged", 32'h0, 32'h303);
    wr_ok(32'h0, 32'h0, 4'b0001);
    rd_chk("ctrl_strb", 32'h0, 32'h300);
    wr_ok(32'h8, 32'h0, 4'b0000);
    rd_chk("tx_strb0", 32'h8, 32'h3);
    // reset while the response is being presented
    @(negedge clk);
    valid = 1'b1; write = 1'b1; addr = 32'h0; wdata = 32'h3; wstrb = 4'hF;
    @(negedge clk);
    chk("rst_resp_ready", {31'd0, ready}, 32'd1);
    valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_pulse", {31'd0, ready}, 32'd0);
    rd_chk("rd_ctrl_after", 32'h0, 32'h300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule

// File: doc/serial_link_cfg_responder.md
# serial_link_cfg_responder

Register-bus target that terminates the serial link's configuration port: it holds the link control register, the TX/RX channel-allocator configuration, and the AXI isolation status. It drives clock-gate, link-reset, isolation-request and allocator-config outputs into the link datapath. It answers every register access with a registered one-cycle response. An optional watchdog flags isolation handshakes that fail to complete.

## Interface
Parameters:
- `AddrWidth`, default 32: register-bus address width; only bits [3:2] are decoded, and bits [AddrWidth-1:4] must be zero.
- `TimeoutCycles`, default 1024: isolation handshake watchdog limit in cycles, ≥2.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `reg_valid_i`, in, 1: request valid; the initiator holds the request stable until `reg_ready_o`.
- `reg_write_i`, in, 1: 1 = write, 0 = read.
- `reg_addr_i`, in, AddrWidth: byte address.
- `reg_wdata_i`, in, 32: write data.
- `reg_wstrb_i`, in, 4: byte strobes.
- `reg_ready_o`, out, 1: response valid, one-cycle pulse.
- `reg_rdata_o`, out, 32: read data, valid with `reg_ready_o`; 0 otherwise.
- `reg_error_o`, out, 1: access error, valid with `reg_ready_o`.
- `clk_ena_o`, out, 1: link clock enable (CTRL[0]).
- `link_rst_no`, out, 1: link reset, active-low (CTRL[1]).
- `isolate_req_o`, out, 2: [0] AXI-in, [1] AXI-out isolation request (CTRL[8], CTRL[9]).
- `isolated_i`, in, 2: isolation status from the isolate units.
- `alloc_tx_cfg_o`, out, 2: {auto_flush, bypass}, TX channel allocator.
- `alloc_rx_cfg_o`, out, 2: {auto_flush, bypass}, RX channel allocator.
- `timeout_o`, out, 1: OR of the sticky timeout bits.

## Operation
Register map (word offsets):
- 0x00 CTRL, RW. Implemented bits: [0] clk_ena, [1] link_rst_n, [8] iso_in, [9] iso_out. Reset value 0x300. Unimplemented bits read 0.
- 0x04 ISOLATED. [1:0] are read-only and report `isolated_i` as registered one cycle. [9:8] are sticky timeout bits, write-1-to-clear. Writes to [1:0] are ignored and raise no error.
- 0x08 CH_ALLOC_TX_CFG, RW. [1:0] only. Reset value 0.
- 0x0C CH_ALLOC_RX_CFG, RW. [1:0] only. Reset value 0.

Access rules:
- Byte strobes gate writes per byte; `wstrb=0` writes nothing and is still acknowledged without error.
- Any address with bits outside [3:2] set, or with misaligned [1:0], gives `reg_error_o=1`, `reg_rdata_o=0`, and no state change.

Response FSM:
- IDLE: on `reg_valid_i`, capture the request, perform the write or sample the read, then go to RESP.
- RESP: assert `reg_ready_o` with rdata/error for exactly one cycle, ignore `reg_valid_i`, then go to IDLE.

Watchdog, per direction k:
- The counter clears whenever `isolate_req_o[k] == isolated_q[k]`. Otherwise it increments and saturates at TimeoutCycles.
- Reaching TimeoutCycles sets ISOLATED[8+k].
- If a set and a W1C clear happen in the same cycle, set wins.

## Timing
- Request sampled in IDLE at edge N. Registers and outputs update at edge N. `reg_ready_o` is high in cycle N+1. The next accept is possible at edge N+2.
- Read data reflects register state before the same-access write.
- On reset, all outputs are:
  - `reg_ready_o=0`, `reg_rdata_o=0`, `reg_error_o=0`
  - `clk_ena_o=0`, `link_rst_no=0`, `isolate_req_o=2'b11`
  - `alloc_tx_cfg_o=0`, `alloc_rx_cfg_o=0`, `timeout_o=0`
  - FSM returns to IDLE and counters go to 0.
- Reset asserted mid-access drops the pending response. The initiator must reissue the access.
- The isolation status read path adds one register stage: `isolated_i` changes at edge M are visible to reads sampled at edge M+1 or later.

## Configuration
- `SERIAL_LINK_CFG_TIMEOUT_EN` defined: watchdog counters and sticky bits ISOLATED[9:8] are present, and `timeout_o` is driven as above.
- Not defined: no counters are instantiated, ISOLATED[9:8] read 0, writes to them are ignored, and `timeout_o` is tied to 0.

## Test plan
- Reset, then read all four registers → CTRL=0x300, ISOLATED=0x3 (with `isolated_i=2'b11`), TX=0, RX=0; all with `reg_error_o=0` and `reg_ready_o` exactly one cycle after accept.
- Bring-up sequence:
  - write CTRL=0x300 → `link_rst_no=0`
  - write CTRL=0x302 → `link_rst_no=1`
  - write CTRL=0x303 → `clk_ena_o=1`
  - write TX=0x3 and RX=0x3 → both allocator config outputs = 2'b11
- Write CTRL=0x03 → `isolate_req_o=0`. Drop `isolated_i` to 0 five cycles later; poll ISOLATED → reads 0x3 until the drop, then 0x0, with no timeout bit set.
- With the macro defined, TimeoutCycles=16: write CTRL=0x03 and hold `isolated_i=2'b11` → after 16 cycles ISOLATED=0x303 and `timeout_o=1`. Write 0x100 to ISOLATED → bit 8 clears, bit 9 stays set.
- Read 0x10, and write 0x02 to CTRL → `reg_error_o=1`, `reg_rdata_o=0`, CTRL unchanged. Write CTRL with `wstrb=4'b0001` and data 0x0 → only bits [1:0] clear, CTRL=0x300.
- Assert `rst_i` during RESP → no `reg_ready_o` pulse, all outputs return to reset values on the next edge.
